// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - gray/binary conversion helpers shared by the read-pointer slice
//
// Provides gray2bin, bin2gray, a popcount-greater-than-one test and the FIFO depth
// derivation. The helpers work on a 32-bit word; callers zero-extend their pointer
// and truncate the result, which is exact because leading zeros never change
// either conversion.

package gray_pkg;

    localparam int PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    // FIFO depth for a pointer of the given width (the MSB is the wrap bit).
    function automatic int depth_of(input int length);
        return 1 << (length - 1);
    endfunction

    // Prefix XOR from the MSB down.
    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Clearing the lowest set bit leaves something non-zero only if two or more
    // bits were set.
    function automatic logic multi_bit(input ptr_word_t x);
        return (x & (x - ptr_word_t'(1))) != '0;
    endfunction

endpackage

// File: rtl/gray_decode_stage.sv
// rtl/gray_decode_stage.sv - captures the synchronized write gray pointer, decodes it and flags illegal jumps
//
// Ports:
//   clk            read-domain clock
//   reset          synchronous active-high reset
//   wr_gray_synced write pointer in gray code, already synchronized to clk
//   wr_bin_next    binary decode of the captured gray pointer
//   jump_err       combinational pulse: more than one bit differs between the
//                  incoming and the captured gray pointer

module gray_decode_stage
    import gray_pkg::*;
#(
    parameter int LENGTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LENGTH-1:0] wr_gray_synced,
    output logic [LENGTH-1:0] wr_bin_next,
    output logic              jump_err
);

    logic [LENGTH-1:0] wr_gray_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_gray_q <= '0;
        end else begin
            wr_gray_q <= wr_gray_synced;
        end
    end

    assign wr_bin_next = LENGTH'(gray2bin(ptr_word_t'(wr_gray_q)));

    // The check compares against the value being replaced at this edge, so the
    // sticky flag in the top rises on the same edge that captures the bad code.
    assign jump_err = ~reset & multi_bit(ptr_word_t'(wr_gray_synced ^ wr_gray_q));

endmodule

// File: rtl/gray_read_pointer.sv
// rtl/gray_read_pointer.sv - read-side pointer, status and error tracking of a dual-clock FIFO
//
// Ports:
//   clk            read-domain clock
//   reset          synchronous active-high reset
//   wr_gray_synced synchronized write pointer (gray)
//   rd_en          read request
//   rd_addr        RAM read address (low bits of the binary read pointer)
//   rd_gray        registered gray read pointer for the write domain
//   rd_accept      read taken this cycle (combinational)
//   empty          registered, level == 0
//   level          registered occupancy, unclamped
//   underflow      one-cycle pulse after a read request while empty
//   ptr_error      sticky: illegal gray jump or occupancy above DEPTH

module gray_read_pointer
    import gray_pkg::*;
#(
    parameter int LENGTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LENGTH-1:0] wr_gray_synced,
    input  logic              rd_en,
    output logic [LENGTH-2:0] rd_addr,
    output logic [LENGTH-1:0] rd_gray,
    output logic              rd_accept,
    output logic              empty,
    output logic [LENGTH-1:0] level,
    output logic              underflow,
    output logic              ptr_error
);

    localparam int              DEPTH   = depth_of(LENGTH);
    localparam logic [LENGTH:0] DEPTH_W = (LENGTH + 1)'(DEPTH);

    logic [LENGTH-1:0] rd_bin;
    logic [LENGTH-1:0] rd_bin_next;
    logic [LENGTH-1:0] wr_bin_next;
    logic [LENGTH-1:0] level_next;
    logic              jump_err;
    logic              overrun;

    gray_decode_stage #(
        .LENGTH (LENGTH)
    ) u_decode (
        .clk            (clk),
        .reset          (reset),
        .wr_gray_synced (wr_gray_synced),
        .wr_bin_next    (wr_bin_next),
        .jump_err       (jump_err)
    );

    assign rd_accept   = rd_en & ~empty & ~reset;
    assign rd_bin_next = rd_bin + LENGTH'(rd_accept);

    // Subtraction across the full width including the wrap bit, so a full FIFO
    // reads as DEPTH rather than as zero.
    assign level_next  = wr_bin_next - rd_bin_next;
    assign overrun     = {1'b0, level_next} > DEPTH_W;

    assign rd_addr     = rd_bin[LENGTH-2:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_bin    <= '0;
            rd_gray   <= '0;
            level     <= '0;
            empty     <= 1'b1;
            underflow <= 1'b0;
            ptr_error <= 1'b0;
        end else begin
            rd_bin    <= rd_bin_next;
            rd_gray   <= LENGTH'(bin2gray(ptr_word_t'(rd_bin_next)));
            level     <= level_next;
            empty     <= (level_next == '0);
            underflow <= rd_en & empty;
            if (jump_err || overrun) begin
                ptr_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gray_read_pointer.sv
// tb/tb_gray_read_pointer.sv - directed vector bench for gray_read_pointer at LENGTH=4

module tb_gray_read_pointer;

    localparam int LENGTH = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [LENGTH-1:0] wr_gray_synced = '0;
    logic              rd_en = 1'b0;
    logic [LENGTH-2:0] rd_addr;
    logic [LENGTH-1:0] rd_gray;
    logic              rd_accept;
    logic              empty;
    logic [LENGTH-1:0] level;
    logic              underflow;
    logic              ptr_error;

    int n_tests = 0;
    int n_fail  = 0;

    gray_read_pointer #(
        .LENGTH (LENGTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .wr_gray_synced (wr_gray_synced),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_gray        (rd_gray),
        .rd_accept      (rd_accept),
        .empty          (empty),
        .level          (level),
        .underflow      (underflow),
        .ptr_error      (ptr_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       rd;
        logic [3:0] wg;
        logic       acc;
        logic [2:0] addr;
        logic [3:0] rg;
        logic       emp;
        logic [3:0] lvl;
        logic       uf;
        logic       err;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rd, input logic [3:0] wg);
        @(negedge clk);
        reset          = r;
        rd_en          = rd;
        wr_gray_synced = wg;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input logic r, input logic rd, input logic [3:0] wg);
        drive(r, rd, wg);
        tick();
    endtask

    function automatic logic [3:0] g(input int n);
        logic [3:0] b;
        b = 4'(n);
        return b ^ (b >> 1);
    endfunction

    initial begin
        //            rst   rd    wg       acc   addr  rg       emp   lvl   uf    err
        vecs[0]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 3'd0, 4'b0000, 1'b1, 4'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 4'b0001, 1'b0, 3'd0, 4'b0000, 1'b1, 4'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 4'b0011, 1'b0, 3'd0, 4'b0000, 1'b0, 4'd1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 4'b0011, 1'b0, 3'd0, 4'b0000, 1'b0, 4'd2, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 4'b0010, 1'b0, 3'd0, 4'b0000, 1'b0, 4'd2, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 4'b0010, 1'b0, 3'd0, 4'b0000, 1'b0, 4'd3, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 4'b0010, 1'b1, 3'd1, 4'b0001, 1'b0, 4'd2, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 4'b0010, 1'b1, 3'd2, 4'b0011, 1'b0, 4'd1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 4'b0010, 1'b1, 3'd3, 4'b0010, 1'b1, 4'd0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 4'b0010, 1'b0, 3'd3, 4'b0010, 1'b1, 4'd0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 4'b0010, 1'b0, 3'd3, 4'b0010, 1'b1, 4'd0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 4'b0110, 1'b0, 3'd3, 4'b0010, 1'b1, 4'd0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 4'b0111, 1'b0, 3'd3, 4'b0010, 1'b0, 4'd1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 4'b0101, 1'b0, 3'd3, 4'b0010, 1'b0, 4'd2, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 4'b0100, 1'b0, 3'd3, 4'b0010, 1'b0, 4'd3, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 4'b0100, 1'b0, 3'd3, 4'b0010, 1'b0, 4'd4, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 4'b1100, 1'b0, 3'd3, 4'b0010, 1'b0, 4'd4, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 4'b1100, 1'b1, 3'd4, 4'b0110, 1'b0, 4'd4, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b1, 4'b1100, 1'b0, 3'd0, 4'b0000, 1'b1, 4'd0, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 4'b0000, 1'b1, 4'd0, 1'b0, 1'b0};

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].rst, vecs[i].rd, vecs[i].wg);
            chk($sformatf("v%0d rd_accept", i), int'(rd_accept), int'(vecs[i].acc));
            tick();
            chk($sformatf("v%0d rd_addr", i),   int'(rd_addr),   int'(vecs[i].addr));
            chk($sformatf("v%0d rd_gray", i),   int'(rd_gray),   int'(vecs[i].rg));
            chk($sformatf("v%0d empty", i),     int'(empty),     int'(vecs[i].emp));
            chk($sformatf("v%0d level", i),     int'(level),     int'(vecs[i].lvl));
            chk($sformatf("v%0d underflow", i), int'(underflow), int'(vecs[i].uf));
            chk($sformatf("v%0d ptr_error", i), int'(ptr_error), int'(vecs[i].err));
        end

        // Wrap-around: bring both pointers to 15, then one write and one read.
        for (int n = 1; n <= 7; n++) st(1'b0, 1'b0, g(n));
        st(1'b0, 1'b0, g(7));
        chk("wrap fill7 level", int'(level), 7);
        for (int i = 0; i < 7; i++) st(1'b0, 1'b1, g(7));
        chk("wrap drain7 level", int'(level), 0);
        chk("wrap drain7 empty", int'(empty), 1);
        chk("wrap drain7 rd_addr", int'(rd_addr), 7);
        for (int n = 8; n <= 15; n++) st(1'b0, 1'b0, g(n));
        st(1'b0, 1'b0, g(15));
        chk("full level", int'(level), 8);
        chk("full empty", int'(empty), 0);
        chk("full ptr_error", int'(ptr_error), 0);
        for (int i = 0; i < 8; i++) st(1'b0, 1'b1, g(15));
        chk("at15 rd_gray", int'(rd_gray), 4'b1000);
        chk("at15 empty", int'(empty), 1);
        st(1'b0, 1'b0, 4'b0000);
        st(1'b0, 1'b0, 4'b0000);
        chk("wrap write level", int'(level), 1);
        chk("wrap write empty", int'(empty), 0);
        drive(1'b0, 1'b1, 4'b0000);
        chk("wrap read rd_accept", int'(rd_accept), 1);
        tick();
        chk("wrap read rd_gray", int'(rd_gray), 4'b0000);
        chk("wrap read rd_addr", int'(rd_addr), 0);
        chk("wrap read empty", int'(empty), 1);
        chk("wrap read level", int'(level), 0);
        chk("wrap read ptr_error", int'(ptr_error), 0);

        // Full, then an illegal two-bit jump 1100 -> 0110.
        st(1'b1, 1'b0, 4'b0000);
        for (int n = 1; n <= 8; n++) st(1'b0, 1'b0, g(n));
        st(1'b0, 1'b0, g(8));
        chk("full8 level", int'(level), 8);
        chk("full8 empty", int'(empty), 0);
        chk("full8 ptr_error", int'(ptr_error), 0);
        st(1'b0, 1'b0, 4'b0110);
        chk("jump ptr_error", int'(ptr_error), 1);
        drive(1'b0, 1'b1, 4'b0110);
        chk("error read rd_accept", int'(rd_accept), 1);
        tick();
        for (int i = 0; i < 3; i++) st(1'b0, 1'b0, 4'b0110);
        chk("sticky ptr_error", int'(ptr_error), 1);
        st(1'b1, 1'b0, 4'b0000);
        chk("reset clears ptr_error", int'(ptr_error), 0);

        // Overrun: nine writes with no reads.
        for (int n = 1; n <= 9; n++) st(1'b0, 1'b0, g(n));
        st(1'b0, 1'b0, g(9));
        chk("overrun level", int'(level), 9);
        chk("overrun ptr_error", int'(ptr_error), 1);
        st(1'b1, 1'b0, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_read_pointer.md
Name: gray_read_pointer

Overview:
- Read-side pointer block of a dual-clock FIFO. It is the receiving end of a gray-coded write pointer that a counter in the write domain has produced and a two-flop stage has synchronized into this domain.
- Decodes the synchronized gray pointer to binary and checks it for illegal multi-bit jumps.
- Maintains the local read pointer and its gray-coded copy for the return path to the write domain.
- Produces empty, level and underflow status.
- Sits in the read clock domain, between the synchronizer and the FIFO RAM read port.

Parameters:
- LENGTH, 8, pointer width including wrap bit. FIFO depth is DEPTH = 2^(LENGTH-1). RAM address width is LENGTH-1.

Ports:
- clk  input  1  read-domain clock
- reset  input  1  synchronous, active-high reset, sampled on posedge clk
- wr_gray_synced  input  LENGTH  write pointer in gray code, already synchronized to clk
- rd_en  input  1  read request
- rd_addr  output  LENGTH-1  RAM read address, equal to rd_bin[LENGTH-2:0]
- rd_gray  output  LENGTH  registered gray code of the read pointer, for synchronization into the write domain
- rd_accept  output  1  combinational; equals rd_en & ~empty & ~reset
- empty  output  1  registered; high when level == 0
- level  output  LENGTH  registered occupancy, range 0..DEPTH
- underflow  output  1  registered one-cycle pulse for rd_en while empty
- ptr_error  output  1  sticky error flag

Behaviour:
- Reset values: rd_bin=0, rd_addr=0, rd_gray=0, wr_gray_q=0, wr_bin=0, empty=1, level=0, underflow=0, ptr_error=0.
- Reset dominates rd_en in the same cycle. A reset mid-operation discards all pointer state; no read is accepted on a reset cycle.
- Decode stage:
  - Edge k: wr_gray_q <= wr_gray_synced.
  - Edge k+1: wr_bin <= gray2bin(wr_gray_q). gray2bin is prefix XOR from the MSB down.
- Gray check:
  - At edge k, if popcount(wr_gray_synced ^ wr_gray_q) > 1, set ptr_error.
  - Zero or one bit changing is legal.
- Read pointer:
  - At each edge with rd_accept=1: rd_bin <= rd_bin + 1, modulo 2^LENGTH.
  - At every edge: rd_gray <= bin2gray(rd_bin_next), where bin2gray(b) = b ^ (b >> 1), and rd_bin_next is the incremented value if rd_accept=1, otherwise rd_bin.
- Status (all registered at the same edge that loads rd_bin and wr_bin, from the _next values):
  - level <= (wr_bin_next - rd_bin_next) mod 2^LENGTH.
  - empty <= (wr_bin_next == rd_bin_next).
  - wr_bin_next = gray2bin(wr_gray_q).
- Latency:
  - A write-pointer change on wr_gray_synced is reflected in empty/level 2 edges later.
  - A read is reflected in rd_addr, rd_gray, empty and level at the next edge.
- Simultaneous read and write-pointer advance in one cycle: level stays unchanged, and both pointers advance.
- Wrap-around: rd_bin goes from 2^LENGTH-1 to 0. rd_gray changes in one bit only, clearing the MSB. Empty is computed across the wrap bit, so full (level == DEPTH) is never mistaken for empty.
- Overrun: if computed level > DEPTH, set ptr_error. Level is output unclamped.
- Underflow: rd_en=1 while empty=1 produces:
  - underflow=1 for exactly one cycle after the edge;
  - no pointer change;
  - rd_accept=0.
- ptr_error is cleared only by reset. It does not block reads.

Decomposition:
- Package gray_pkg:
  - functions gray2bin(LENGTH) and bin2gray(LENGTH);
  - popcount-greater-than-one helper;
  - DEPTH localparam derivation.
- One sub-module, gray_decode_stage:
  - contains the wr_gray_q register and the multi-bit-jump check;
  - outputs wr_bin_next and a jump-error pulse.
- Top level holds the read pointer, status registers and sticky ptr_error.

Test Plan (LENGTH=4, DEPTH=8):
1. Reset, then wr_gray_synced stepped 0000->0001->0011 on consecutive cycles -> empty falls 2 edges after the first step; level=1 then 2. ptr_error stays 0.
2. Level=3, rd_en held for 4 cycles -> rd_addr 0,1,2,3 then holds. Empty rises after the 3rd read; underflow pulses once on the 4th. rd_gray goes 0001,0011,0010.
3. Pointers at 15 (gray 1000), one write then one read -> rd_bin wraps to 0, rd_gray 1000->0000. Empty=1, level=0, no error.
4. Full case: wr_bin=8, rd_bin=0 -> level=8, empty=0. Then wr_gray_synced jumps from 1100 to 0110 (2 bits) -> ptr_error=1 at that edge and remains 1 until reset.
5. Simultaneous rd_en and write-pointer step at level=4 -> level stays 4 and rd_addr increments. Then assert reset together with rd_en -> next edge shows all reset values and rd_accept=0.
